// File: rtl/rr_slot_arbiter.sv
// rr_slot_arbiter: 4-way round-robin arbiter with bounded hold tenure; `ARB_LOCK_EN adds a lock input.
// Latency: 1 cycle from req to registered grant; at least one dead cycle separates consecutive grants.
// Backpressure: requesters hold req until granted; owner leaves via done, dropping req, or hold timeout.
module rr_slot_arbiter #(
    parameter int MAX_HOLD = 8,
    parameter int HOLD_W   = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic [3:0] done,
`ifdef ARB_LOCK_EN
    input  logic       lock,
`endif
    output logic [3:0] grant,
    output logic [1:0] grant_id,
    output logic       grant_valid,
    output logic       timeout,
    output logic [1:0] ptr
);

    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    state_t            state, state_nxt;
    logic [3:0]        grant_nxt;
    logic [1:0]        grant_id_nxt;
    logic [1:0]        ptr_nxt;
    logic              timeout_nxt;
    logic [HOLD_W-1:0] hold_cnt, hold_nxt;
    logic              lock_act;
    logic [3:0]        req_rot;
    logic [1:0]        win_off;
    logic [1:0]        win_id;
    logic              hold_exp;
    logic              rel;

`ifdef ARB_LOCK_EN
    assign lock_act = lock;
`else
    assign lock_act = 1'b0;
`endif

    // Rotate req so the search always starts at bit 0, then map the offset back.
    always_comb begin
        req_rot = 4'({req, req} >> ptr);
        win_off = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (req_rot[i]) win_off = 2'(i);
        end
        win_id = ptr + win_off;
    end

    assign hold_exp = (hold_cnt == HOLD_LAST) && !lock_act;
    assign rel      = done[grant_id] || !req[grant_id] || hold_exp;

    always_comb begin
        state_nxt    = state;
        grant_nxt    = grant;
        grant_id_nxt = grant_id;
        ptr_nxt      = ptr;
        hold_nxt     = hold_cnt;
        timeout_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (|req) begin
                    state_nxt    = BUSY;
                    grant_nxt    = 4'b0001 << win_id;
                    grant_id_nxt = win_id;
                    ptr_nxt      = win_id + 2'd1;
                    hold_nxt     = '0;
                end
            end
            BUSY: begin
                if (!lock_act && hold_cnt != HOLD_LAST) hold_nxt = hold_cnt + HOLD_W'(1);
                if (rel) begin
                    state_nxt   = IDLE;
                    grant_nxt   = 4'b0000;
                    // Only a pure hold expiry counts as a forced release.
                    timeout_nxt = hold_exp && req[grant_id] && !done[grant_id];
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            grant    <= 4'b0000;
            grant_id <= 2'd0;
            ptr      <= 2'd0;
            hold_cnt <= '0;
            timeout  <= 1'b0;
        end else begin
            state    <= state_nxt;
            grant    <= grant_nxt;
            grant_id <= grant_id_nxt;
            ptr      <= ptr_nxt;
            hold_cnt <= hold_nxt;
            timeout  <= timeout_nxt;
        end
    end

    assign grant_valid = |grant;

endmodule

// File: tb/tb_rr_slot_arbiter.sv
// Directed bench for rr_slot_arbiter (MAX_HOLD=8); lock scenario runs when ARB_LOCK_EN is defined.
module tb_rr_slot_arbiter;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] done;
    logic       lock;
    logic [3:0] grant;
    logic [1:0] grant_id;
    logic       grant_valid;
    logic       timeout;
    logic [1:0] ptr;

    int n_tests = 0;
    int n_fail  = 0;

    rr_slot_arbiter #(.MAX_HOLD(8), .HOLD_W(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .done        (done),
`ifdef ARB_LOCK_EN
        .lock        (lock),
`endif
        .grant       (grant),
        .grant_id    (grant_id),
        .grant_valid (grant_valid),
        .timeout     (timeout),
        .ptr         (ptr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req   = 4'b0000;
        done  = 4'b0000;
        lock  = 1'b0;
        tick();
        tick();
        n_tests++;
        if (grant !== 4'b0000) begin n_fail++; $display("FAIL reset_grant: got %b want 0000", grant); end
        n_tests++;
        if (grant_valid !== 1'b0 || timeout !== 1'b0) begin
            n_fail++; $display("FAIL reset_flags: gv=%b to=%b want 0 0", grant_valid, timeout);
        end
        n_tests++;
        if (ptr !== 2'd0 || grant_id !== 2'd0) begin
            n_fail++; $display("FAIL reset_ptr_id: ptr=%0d id=%0d want 0 0", ptr, grant_id);
        end
        rst_n = 1'b1;
        tick();
        n_tests++;
        if (grant_valid !== 1'b0) begin n_fail++; $display("FAIL reset_idle_no_req: gv=%b want 0", grant_valid); end
    endtask

    // ptr=0, lone request from 2.
    task automatic test_single();
        req = 4'b0100;
        tick();
        n_tests++;
        if (grant !== 4'b0100 || grant_id !== 2'd2 || grant_valid !== 1'b1) begin
            n_fail++; $display("FAIL single_grant: grant=%b id=%0d gv=%b want 0100 2 1", grant, grant_id, grant_valid);
        end
        n_tests++;
        if (ptr !== 2'd3) begin n_fail++; $display("FAIL single_ptr: got %0d want 3", ptr); end
        done = 4'b0100;
        tick();
        n_tests++;
        if (grant !== 4'b0000 || grant_valid !== 1'b0 || timeout !== 1'b0) begin
            n_fail++; $display("FAIL single_release: grant=%b gv=%b to=%b want 0000 0 0", grant, grant_valid, timeout);
        end
        n_tests++;
        if (grant_id !== 2'd2) begin n_fail++; $display("FAIL single_id_hold: got %0d want 2", grant_id); end
        done = 4'b0000;
        req  = 4'b0000;
        tick();
    endtask

    // ptr=3: winner 3 wraps ptr; non-owner done and req changes are ignored.
    task automatic test_wrap_ignored();
        req = 4'b1001;
        tick();
        n_tests++;
        if (grant !== 4'b1000 || grant_id !== 2'd3 || ptr !== 2'd0) begin
            n_fail++; $display("FAIL wrap_grant: grant=%b id=%0d ptr=%0d want 1000 3 0", grant, grant_id, ptr);
        end
        done = 4'b0001;
        req  = 4'b1011;
        tick();
        n_tests++;
        if (grant !== 4'b1000) begin n_fail++; $display("FAIL wrap_foreign_done: grant=%b want 1000", grant); end
        done = 4'b0000;
        req  = 4'b1101;
        tick();
        n_tests++;
        if (grant !== 4'b1000) begin n_fail++; $display("FAIL wrap_foreign_req: grant=%b want 1000", grant); end
        req = 4'b0001;
        tick();
        n_tests++;
        if (grant_valid !== 1'b0 || timeout !== 1'b0) begin
            n_fail++; $display("FAIL wrap_req_drop: gv=%b to=%b want 0 0", grant_valid, timeout);
        end
        req  = 4'b0000;
        done = 4'b1111;
        tick();
        n_tests++;
        if (grant_valid !== 1'b0 || ptr !== 2'd0) begin
            n_fail++; $display("FAIL idle_done_ignored: gv=%b ptr=%0d want 0 0", grant_valid, ptr);
        end
        done = 4'b0000;
    endtask

    // All requesting from ptr=0; each owner pulses done in its second cycle.
    task automatic test_round_robin();
        logic [1:0] exp_id;
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            exp_id = 2'(k % 4);
            tick();
            n_tests++;
            if (grant_valid !== 1'b1 || grant_id !== exp_id || grant !== (4'b0001 << exp_id)) begin
                n_fail++;
                $display("FAIL rr_grant[%0d]: grant=%b id=%0d want id %0d", k, grant, grant_id, exp_id);
            end
            tick();
            n_tests++;
            if (grant_id !== exp_id || grant_valid !== 1'b1) begin
                n_fail++; $display("FAIL rr_hold[%0d]: id=%0d gv=%b want %0d 1", k, grant_id, grant_valid, exp_id);
            end
            done = 4'b0001 << exp_id;
            tick();
            done = 4'b0000;
            n_tests++;
            if (grant_valid !== 1'b0) begin n_fail++; $display("FAIL rr_dead[%0d]: gv=%b want 0", k, grant_valid); end
        end
        n_tests++;
        if (ptr !== 2'd1) begin n_fail++; $display("FAIL rr_ptr_end: got %0d want 1", ptr); end
        req = 4'b0000;
        tick();
    endtask

    // MAX_HOLD=8: forced release, one dead cycle, regrant; then done coinciding with expiry.
    task automatic test_timeout();
        req = 4'b0001;
        tick();
        n_tests++;
        if (grant !== 4'b0001 || timeout !== 1'b0) begin
            n_fail++; $display("FAIL to_first: grant=%b to=%b want 0001 0", grant, timeout);
        end
        for (int i = 2; i <= 8; i++) begin
            tick();
            n_tests++;
            if (grant_valid !== 1'b1 || timeout !== 1'b0) begin
                n_fail++; $display("FAIL to_tenure[%0d]: gv=%b to=%b want 1 0", i, grant_valid, timeout);
            end
        end
        tick();
        n_tests++;
        if (grant_valid !== 1'b0 || timeout !== 1'b1) begin
            n_fail++; $display("FAIL to_release: gv=%b to=%b want 0 1", grant_valid, timeout);
        end
        tick();
        n_tests++;
        if (grant !== 4'b0001 || timeout !== 1'b0) begin
            n_fail++; $display("FAIL to_regrant: grant=%b to=%b want 0001 0", grant, timeout);
        end
        for (int i = 2; i <= 8; i++) begin
            tick();
            n_tests++;
            if (grant_valid !== 1'b1) begin n_fail++; $display("FAIL to_tenure2[%0d]: gv=%b want 1", i, grant_valid); end
        end
        done = 4'b0001;
        tick();
        n_tests++;
        if (grant_valid !== 1'b0 || timeout !== 1'b0) begin
            n_fail++; $display("FAIL to_done_and_expiry: gv=%b to=%b want 0 0", grant_valid, timeout);
        end
        done = 4'b0000;
        req  = 4'b0000;
        tick();
    endtask

    // ptr=1: grant requester 1, then async reset mid-tenure.
    task automatic test_reset_mid();
        req = 4'b0010;
        tick();
        n_tests++;
        if (grant !== 4'b0010) begin n_fail++; $display("FAIL rstmid_pre: grant=%b want 0010", grant); end
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (grant !== 4'b0000 || grant_valid !== 1'b0 || ptr !== 2'd0 || timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_async: grant=%b gv=%b ptr=%0d to=%b want 0000 0 0 0", grant, grant_valid, ptr, timeout);
        end
        tick();
        n_tests++;
        if (timeout !== 1'b0 || grant_valid !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_held: to=%b gv=%b want 0 0", timeout, grant_valid);
        end
        req   = 4'b0000;
        rst_n = 1'b1;
        tick();
    endtask

`ifdef ARB_LOCK_EN
    task automatic test_lock();
        lock = 1'b1;
        req  = 4'b0001;
        tick();
        for (int i = 0; i < 12; i++) begin
            tick();
            n_tests++;
            if (grant_valid !== 1'b1 || timeout !== 1'b0) begin
                n_fail++; $display("FAIL lock_held[%0d]: gv=%b to=%b want 1 0", i, grant_valid, timeout);
            end
        end
        lock = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            tick();
            n_tests++;
            if (grant_valid !== 1'b1) begin n_fail++; $display("FAIL lock_count[%0d]: gv=%b want 1", i, grant_valid); end
        end
        tick();
        n_tests++;
        if (grant_valid !== 1'b0 || timeout !== 1'b1) begin
            n_fail++; $display("FAIL lock_release: gv=%b to=%b want 0 1", grant_valid, timeout);
        end
        req = 4'b0000;
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_wrap_ignored();
        test_round_robin();
        test_timeout();
        test_reset_mid();
`ifdef ARB_LOCK_EN
        test_lock();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rr_slot_arbiter.md
Name: rr_slot_arbiter

Overview:
- Round-robin arbiter that shares one resource (e.g. a counter/timer datapath) among 4 requesters.
- A 2-bit wrapping rotation pointer sets search priority; a hold timer bounds each tenure.
- Sits between requester blocks and the shared resource.
- Drives a one-hot grant and a binary grant ID used as the resource's input mux select.

Parameters:
- MAX_HOLD, 8, max cycles one owner may hold the grant before forced release (legal range 2..2**HOLD_W).
- HOLD_W, 4, width of internal hold counter.

Ports:
- clk  input  1  rising-edge clock, single clock domain.
- rst_n  input  1  asynchronous active-low reset.
- req  input  4  per-requester request level; held high while ownership is wanted.
- done  input  4  per-requester release pulse; only the bit of the current owner is honoured.
- lock  input  1  present only with ARB_LOCK_EN; owner asserts to extend tenure.
- grant  output  4  one-hot grant, registered; all-zero when no owner.
- grant_id  output  2  binary index of owner; valid when grant_valid=1.
- grant_valid  output  1  high while any grant bit is high.
- timeout  output  1  one-cycle pulse on forced release.
- ptr  output  2  current rotation pointer (debug/observability).

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, grant=0000, grant_id=00, grant_valid=0, timeout=0, ptr=00, hold_cnt=0.
  - Deassertion is sampled on the next clk rising edge.
- States: IDLE, BUSY.
- IDLE:
  - Search req starting at index ptr, ascending with wrap 3->0; the first set bit wins.
  - If there is a winner: the next edge registers grant=one-hot(winner), grant_id=winner, grant_valid=1, ptr=(winner+1) mod 4, hold_cnt=0, and the state moves to BUSY.
  - Latency from req sampled high to grant visible is 1 cycle.
  - If there is no request: outputs and ptr are unchanged.
- BUSY, each cycle:
  - hold_cnt increments, saturating at MAX_HOLD-1.
  - Release condition (evaluated on current-cycle inputs):
    - (a) done[grant_id]=1, or
    - (b) req[grant_id]=0, or
    - (c) hold_cnt==MAX_HOLD-1.
  - On release, the next edge sets grant=0000, grant_valid=0, state=IDLE. grant_id holds its last value.
  - If the release is caused only by (c), timeout=1 for exactly that one cycle. If (a) or (b) fires together with (c), timeout stays 0.
  - Maximum tenure is exactly MAX_HOLD cycles of grant_valid=1.
- Dead cycle: after every release there is at least one cycle with grant_valid=0; back-to-back grants are never issued.
- Fairness: ptr advances past each winner, so with all requesters continuously active the grant order is strictly 0,1,2,3,0,…
- Worst-case wait for any requester: 3 tenures plus 4 dead cycles.
- Boundary conditions:
  - done bits of non-owners are ignored.
  - done is ignored in IDLE.
  - req changes in non-owner bits during BUSY do not affect the current tenure.
  - Winner 3 wraps ptr to 0.
  - A requester that drops req and re-raises it in the dead cycle competes normally from the new ptr.
  - Reset mid-tenure clears grant immediately (asynchronously) and no timeout pulse is generated.
- grant is always one-hot or zero; grant_valid always equals OR of grant.

Optional Feature:
- Macro: ARB_LOCK_EN.
- Defined:
  - lock port exists.
  - In BUSY with lock=1, release condition (c) is suppressed and hold_cnt holds at its current value.
  - (a) and (b) still release the grant.
  - lock is ignored in IDLE.
- Undefined:
  - No lock port.
  - The timeout always applies.

Test Plan:
- Reset: assert rst_n=0 mid-run with grant=0010 -> grant=0000, grant_valid=0, ptr=00, timeout=0 immediately, no clock required.
- Single request: req=0100 from IDLE, ptr=0 -> after 1 cycle grant=0100, grant_id=2, ptr=3; done=0100 pulse -> grant=0000 next cycle.
- Round-robin: req=1111 held, each owner pulses done after 2 cycles -> grant_id sequence 0,1,2,3,0 with one idle cycle between grants.
- Timeout: MAX_HOLD=8, req=0001 held, no done -> grant_valid high exactly 8 cycles, timeout pulses once on the release edge, regrant to requester 0 after one dead cycle.
- Wrap and ignored inputs: ptr=3, req=1001 -> grant 1000 then ptr=0; done=0001 during that tenure -> no release.
- Lock (ARB_LOCK_EN): MAX_HOLD=8, lock=1 held for 12 cycles -> no timeout, grant held 12+ cycles; lock=0 -> release on hold_cnt condition, timeout=1.
